// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states
// and the alignment rule applied to every incoming request.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // True when the request cannot be issued: illegal size or misaligned address.
    function automatic logic is_bad_access(input size_e sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Little-endian byte-lane handling: extracts and extends load data from a
// memory word, and merges sub-word store data into a previously read word.
module dmem_lane_merge
    import dmem_pkg::*;
#(
    parameter int unsigned WordSize = 32
) (
    input  logic [WordSize-1:0] mem_word,
    input  logic [WordSize-1:0] wdata,
    input  logic [1:0]          addr_lo,
    input  size_e               size,
    input  logic                sext,
    output logic [WordSize-1:0] load_data,
    output logic [WordSize-1:0] merged_word
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select by shift; half lanes use addr[1] only.
    always_comb begin
        byte_sh     = {addr_lo, 3'b000};
        half_sh     = {addr_lo[1], 4'b0000};
        byte_v      = 8'(mem_word >> byte_sh);
        half_v      = 16'(mem_word >> half_sh);
        load_data   = '0;
        merged_word = mem_word;
        case (size)
            SZ_BYTE: begin
                load_data   = {{(WordSize-8){sext & byte_v[7]}}, byte_v};
                merged_word = (mem_word & ~(WordSize'(8'hFF) << byte_sh))
                            | (WordSize'(wdata[7:0]) << byte_sh);
            end
            SZ_HALF: begin
                load_data   = {{(WordSize-16){sext & half_v[15]}}, half_v};
                merged_word = (mem_word & ~(WordSize'(16'hFFFF) << half_sh))
                            | (WordSize'(wdata[15:0]) << half_sh);
            end
            SZ_WORD: begin
                load_data   = mem_word;
                merged_word = wdata;
            end
            default: begin
                load_data   = '0;
                merged_word = mem_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_initiator.sv
// Processor-side data-memory initiator: accepts one load/store at a time,
// performs read / read-modify-write / write cycles on a simple strobe
// interface and returns a single-cycle response.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int unsigned WordSize    = 32,
    parameter int unsigned RD_WAIT_CYC = 1
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    input  logic [WordSize-1:0] req_addr,
    input  logic [WordSize-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [WordSize-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [WordSize-1:0] Mem_Addr,
    output logic                Mem_rd,
    output logic                Mem_wr,
    output logic [WordSize-1:0] Mem_DIN,
    input  logic [WordSize-1:0] Mem_DOUT
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    size_e               size_q, size_d;
    logic                sext_q, sext_d;
    logic [WordSize-1:0] addr_q, addr_d;
    logic [WordSize-1:0] wdata_q, wdata_d;
    logic [WordSize-1:0] din_q, din_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [WordSize-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [WordSize-1:0] load_data;
    logic [WordSize-1:0] merged_word;

    dmem_lane_merge #(
        .WordSize(WordSize)
    ) u_lane_merge (
        .mem_word   (Mem_DOUT),
        .wdata      (wdata_q),
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .sext       (sext_q),
        .load_data  (load_data),
        .merged_word(merged_word)
    );

    // Next-state and datapath updates; response registers change only on entry to RESP.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        din_d       = din_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    sext_d  = req_sext;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (is_bad_access(size_e'(req_size), req_addr[1:0])) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end else if (req_we && (size_e'(req_size) == SZ_WORD)) begin
                        din_d   = req_wdata;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == 32'(RD_WAIT_CYC - 1)) begin
                    if (we_q) begin
                        din_d   = merged_word;
                        state_d = ST_WRITE;
                    end else begin
                        rsp_rdata_d = load_data;
                        rsp_err_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_WRITE: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; async reset drops strobes immediately.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            din_q       <= '0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            din_q       <= din_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Outputs decoded from the state register.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        Mem_rd    = (state_q == ST_READ);
        Mem_wr    = (state_q == ST_WRITE);
        Mem_DIN   = (state_q == ST_WRITE) ? din_q : '0;
        Mem_Addr  = {addr_q[WordSize-1:2], 2'b00};
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator: a byte-array reference model predicts
// each response and latency at accept time; a monitor checks responses.
`timescale 1ns/1ps
module tb_dmem_initiator;

    localparam int unsigned W   = 32;
    localparam int unsigned RDW = 1;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_sext = 1'b0;
    logic [W-1:0]  req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_err;
    logic [W-1:0]  Mem_Addr;
    logic          Mem_rd;
    logic          Mem_wr;
    logic [W-1:0]  Mem_DIN;
    logic [W-1:0]  Mem_DOUT;

    dmem_initiator #(
        .WordSize   (W),
        .RD_WAIT_CYC(RDW)
    ) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_size (req_size),
        .req_sext (req_sext),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .Mem_Addr (Mem_Addr),
        .Mem_rd   (Mem_rd),
        .Mem_wr   (Mem_wr),
        .Mem_DIN  (Mem_DIN),
        .Mem_DOUT (Mem_DOUT)
    );

    always #5 CLK = ~CLK;

    // DUT-facing memory: 16 words, commit on falling edge while Mem_wr is high.
    logic [31:0] dmem [16];
    assign Mem_DOUT = dmem[Mem_Addr[5:2]];
    always @(negedge CLK) if (Mem_wr) dmem[Mem_Addr[5:2]] <= Mem_DIN;

    // Reference memory as plain bytes.
    logic [7:0] refmem [64];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned c0;
    } exp_t;
    exp_t exp_q[$];

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned overlap = 0;
    int unsigned strobe_on_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic sx,
                                   input logic [31:0] a, input logic [31:0] wd, input int unsigned c0);
        exp_t e;
        int unsigned nb;
        logic [31:0] v;
        e.c0 = c0;
        e.rdata = '0;
        e.err = 1'b0;
        if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (!we) begin
            v = '0;
            for (int unsigned i = 0; i < nb; i++) v = v | (32'(refmem[a[5:0] + i]) << (8 * i));
            if (sx && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 1);
            e.rdata = v;
            e.lat = RDW + 1;
        end else begin
            for (int unsigned i = 0; i < nb; i++) refmem[a[5:0] + i] = 8'(wd >> (8 * i));
            e.lat = (nb == 4) ? 2 : RDW + 2;
        end
        return e;
    endfunction

    // Drives one request and holds req_valid high until it is accepted.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input bit push);
        int unsigned n;
        int unsigned c;
        logic rdy;
        @(negedge CLK);
        req_we = we; req_size = sz; req_sext = sx; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        forever begin
            c = cyc;
            rdy = req_ready;
            @(posedge CLK);
            if (rdy) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'(n), 32'd0);
                return;
            end
            @(negedge CLK);
        end
        if (push) exp_q.push_back(model(we, sz, sx, a, wd, c));
    endtask

    task automatic idle(input int unsigned n);
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Response monitor and strobe protocol watch.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (Mem_rd && Mem_wr) overlap++;
            if (exp_q.size() != 0 && exp_q[0].err && (Mem_rd || Mem_wr)) strobe_on_err++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_latency", 32'(cyc - e.c0), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        for (int unsigned i = 0; i < 16; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int unsigned b = 0; b < 4; b++) refmem[4*i+b] = 8'(w >> (8 * b));
        end
        dmem[4] = 32'h8899AABB;
        refmem[16] = 8'hBB; refmem[17] = 8'hAA; refmem[18] = 8'h99; refmem[19] = 8'h88;

        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_rd", 32'(Mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(Mem_wr), 32'd0);
        chk("rst_mem_addr", Mem_Addr, 32'd0);
        chk("rst_mem_din", Mem_DIN, 32'd0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;

        // Directed cases.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        idle(2);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, 1'b1);
        idle(3);
        drain();
        chk("half_store_word", dmem[4], 32'h1234AABB);
        issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 1'b1);
        idle(3);

        // Random traffic, mostly back-to-back.
        for (int unsigned k = 0; k < 300; k++) begin
            logic [1:0] sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 63));
            if (($urandom % 4) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
            if (($urandom % 4) == 0) idle($urandom_range(0, 3));
        end
        idle(2);
        drain();

        // Reset during READ of a sub-word store.
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h5A, 1'b0);
        #1;
        chk("rmw_in_read", 32'(Mem_rd), 32'd1);
        req_valid = 1'b0;
        RST_n = 1'b0;
        #1;
        chk("abort_mem_rd", 32'(Mem_rd), 32'd0);
        chk("abort_mem_wr", 32'(Mem_wr), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        repeat (5) @(negedge CLK);

        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
        idle(4);
        drain();

        for (int unsigned i = 0; i < 16; i++)
            chk("mem_word", dmem[i], {refmem[4*i+3], refmem[4*i+2], refmem[4*i+1], refmem[4*i]});
        chk("rd_wr_overlap", 32'(overlap), 32'd0);
        chk("strobe_on_error", 32'(strobe_on_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
